seg7_scan_driver: RTL



---
 rtl/seg7_scan_driver_if.sv | 28 ++
 rtl/seg7_scan_driver.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle between the service muxes and the 7-segment scan engine.
// The master drives the display request; the slave (scan engine) drives the pins.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int PWM_BITS   = 4
);
  logic                    en;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    flash_all;
  logic [PWM_BITS-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              seg;
  logic                    dp_out;
  logic                    frame_tick;

  modport master (
    output en, digits, dp, blank_mask, blink_mask, flash_all, brightness,
    input  anode, seg, dp_out, frame_tick
  );

  modport slave (
    input  en, digits, dp, blank_mask, blink_mask, flash_all, brightness,
    output anode, seg, dp_out, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan engine: walks NUM_DIGITS digit slots, snapshots the
// display request once per frame, and drives anode/segment pins with blanking,
// blinking, flash-all override, PWM dimming and an anti-ghost dead cycle.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 2048,
  parameter int PWM_BITS     = 4,
  parameter int BLINK_FRAMES = 128,
  parameter bit HEX_EN       = 1'b1,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic             clk_osc,
  input  logic             reset,
  seg7_scan_driver_if.slave bus
);
  localparam int POS_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [POS_W-1:0]      POS_LAST  = POS_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0]      BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);
  // XOR masks that turn active-high internal values into pin polarity
  localparam logic [NUM_DIGITS-1:0] ANODE_POL = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_POL   = {7{ACTIVE_LOW}};

  logic [POS_W-1:0]        pos_q, pos_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_out_q, dp_out_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    frame_start;
  logic [PWM_BITS-1:0]     level;
  logic                    digit_dark;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   anode_on;
  logic [6:0]              seg_on;
  logic                    dp_on;
  logic [3:0]              code_arr [NUM_DIGITS];

  // Glyphs in {g,f,e,d,c,b,a} order, active-high; unknown codes are dark
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = HEX_EN ? 7'h77 : 7'h00;
      4'hB: g = HEX_EN ? 7'h7C : 7'h00;
      4'hC: g = HEX_EN ? 7'h39 : 7'h00;
      4'hD: g = HEX_EN ? 7'h5E : 7'h00;
      4'hE: g = HEX_EN ? 7'h79 : 7'h00;
      default: g = HEX_EN ? 7'h71 : 7'h00;
    endcase
    return g;
  endfunction

  // Unpack the snapshot into per-digit codes so the current slot can index it
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_code
    assign code_arr[gi] = sh_digits_q[4*gi +: 4];
  end

  // Scan counters, frame snapshot and blink timing
  always_comb begin
    frame_start   = (pos_q == '0) && (idx_q == '0);
    pos_d         = pos_q + POS_W'(1);
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    sh_digits_d   = sh_digits_q;
    sh_dp_d       = sh_dp_q;
    sh_blank_d    = sh_blank_q;
    sh_blink_d    = sh_blink_q;
    if (pos_q == POS_LAST) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    // The whole request is latched at once so a frame never mixes old and new data
    if (frame_start) begin
      sh_digits_d = bus.digits;
      sh_dp_d     = bus.dp;
      sh_blank_d  = bus.blank_mask;
      sh_blink_d  = bus.blink_mask;
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  // Pin values for the current slot; anode and segments are registered together
  always_comb begin
    level      = pos_q[POS_W-1 -: PWM_BITS];
    digit_dark = sh_blank_q[idx_q] | (blink_phase_q & sh_blink_q[idx_q]);
    // pos==0 is the dead cycle between digits that prevents ghosting
    lit        = bus.en && (pos_q != '0) && (level <= bus.brightness) &&
                 (bus.flash_all || !digit_dark);
    anode_on   = lit ? (NUM_DIGITS'(1) << idx_q) : '0;
    seg_on     = bus.flash_all ? 7'h7F : seg_decode(code_arr[idx_q]);
    dp_on      = bus.flash_all | sh_dp_q[idx_q];
    anode_d      = anode_on ^ ANODE_POL;
    seg_d        = seg_on ^ SEG_POL;
    dp_out_d     = dp_on ^ ACTIVE_LOW;
    frame_tick_d = frame_start;
  end

  // State and output registers
  always_ff @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      pos_q         <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      sh_digits_q   <= '0;
      sh_dp_q       <= '0;
      sh_blank_q    <= '0;
      sh_blink_q    <= '0;
      anode_q       <= ANODE_POL;
      seg_q         <= SEG_POL;
      dp_out_q      <= ACTIVE_LOW;
      frame_tick_q  <= 1'b0;
    end else begin
      pos_q         <= pos_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      sh_digits_q   <= sh_digits_d;
      sh_dp_q       <= sh_dp_d;
      sh_blank_q    <= sh_blank_d;
      sh_blink_q    <= sh_blink_d;
      anode_q       <= anode_d;
      seg_q         <= seg_d;
      dp_out_q      <= dp_out_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign bus.anode      = anode_q;
  assign bus.seg        = seg_q;
  assign bus.dp_out     = dp_out_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
